// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage types and constants: PC stepping/alignment and the IF/ID bundle.
// Imported by the fetch PC unit, its hold buffer and the IF/ID interface.
package fetch_pc_unit_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned INSTR_LEN = 32;

    localparam logic [WORD_W-1:0] PC_STEP       = WORD_W'(4);
    localparam logic [WORD_W-1:0] PC_ALIGN_MASK = ~WORD_W'(3);

    typedef struct packed {
        logic [WORD_W-1:0]    pc;
        logic [INSTR_LEN-1:0] instr;
        logic                 valid;
    } fetch_bundle_t;

    // Sequential successor; anything at or past the memory bound restarts at 0.
    function automatic logic [WORD_W-1:0] next_seq(input logic [WORD_W-1:0] p,
                                                   input logic [WORD_W-1:0] bound);
        logic [WORD_W-1:0] s;
        s = p + PC_STEP;
        return (s >= bound) ? '0 : s;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: redirect/stall control and imem data in, fetch PC and IF/ID outputs out.
// The slave modport is the fetch unit; master is the surrounding pipeline and memory.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic                 stall;
    logic                 branch_taken;
    logic [WORD_W-1:0]    branch_target;
    logic [INSTR_LEN-1:0] instruction;
    logic [WORD_W-1:0]    pc;
    logic [WORD_W-1:0]    id_pc;
    logic [INSTR_LEN-1:0] id_instr;
    logic                 id_valid;

    modport master (
        output stall, branch_taken, branch_target, instruction,
        input  pc, id_pc, id_instr, id_valid
    );

    modport slave (
        input  stall, branch_taken, branch_target, instruction,
        output pc, id_pc, id_instr, id_valid
    );

endinterface

// File: rtl/fetch_pc_unit_if_hold_buf.sv
// IF/ID stall hold buffer: captures the returned word on the first stall edge so decode
// keeps seeing it while the memory keeps re-reading the already advanced PC.
module if_hold_buf
    import fetch_pc_unit_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 branch_i,
    input  logic                 stall_i,
    input  logic [INSTR_LEN-1:0] instr_i,
    output logic [INSTR_LEN-1:0] id_instr_o
);

    logic [INSTR_LEN-1:0] hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (branch_i) begin
            hold_vld_d = 1'b0;
        end else if (stall_i) begin
            if (!hold_vld_q) begin
                hold_d     = instr_i;
                hold_vld_d = 1'b1;
            end
        end else begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: hold_q is a datapath register, yet it is cleared on reset so no stale word can leak out.
        if (!rst_ni) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign id_instr_o = hold_vld_q ? hold_q : instr_i;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: sequential/branch/stall PC update and pairing of each
// synchronously read instruction with the PC that fetched it for decode.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = '0,
    parameter int unsigned       IMEM_BYTES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_pc_unit_if.slave fif
);

    localparam logic [WORD_W-1:0] IMEM_BOUND = WORD_W'(IMEM_BYTES);

    logic [WORD_W-1:0]    pc_q, pc_d;
    logic [WORD_W-1:0]    fpc_q, fpc_d;
    logic                 vld_q, vld_d;
    logic [INSTR_LEN-1:0] id_instr;
    fetch_bundle_t        id_bundle;

    // Branch beats stall beats advance; a branch squashes the word already in flight.
    always_comb begin
        pc_d  = pc_q;
        fpc_d = fpc_q;
        vld_d = vld_q;
        if (fif.branch_taken) begin
            pc_d  = fif.branch_target & PC_ALIGN_MASK;
            vld_d = 1'b0;
        end else if (!fif.stall) begin
            fpc_d = pc_q;
            vld_d = 1'b1;
            pc_d  = next_seq(pc_q, IMEM_BOUND);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            fpc_q <= RESET_PC;
            vld_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            fpc_q <= fpc_d;
            vld_q <= vld_d;
        end
    end

    if_hold_buf u_hold_buf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .branch_i   (fif.branch_taken),
        .stall_i    (fif.stall),
        .instr_i    (fif.instruction),
        .id_instr_o (id_instr)
    );

    assign id_bundle.pc    = fpc_q;
    assign id_bundle.instr = id_instr;
    assign id_bundle.valid = vld_q;

    assign fif.pc       = pc_q;
    assign fif.id_pc    = id_bundle.pc;
    assign fif.id_instr = id_bundle.instr;
    assign fif.id_valid = id_bundle.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a synchronous 64-byte instruction memory model;
// stimulus pushes expected post-edge state into a scoreboard popped by a monitor.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_pc_unit_if fif ();

    fetch_pc_unit #(.RESET_PC('0), .IMEM_BYTES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hF000_0000 | 32'(i * 4);
        mem[0]  = 32'hABCDEF12;
        mem[1]  = 32'hBCDEF123;
        mem[2]  = 32'hCDEF1234;
        mem[7]  = 32'h23456789;
        mem[13] = 32'h89ABCDEF;
        mem[14] = 32'h9ABCDEF1;
    end

    always @(posedge clk)
        fif.instruction <= (fif.pc < 32'd64) ? mem[fif.pc[5:2]] : 32'hDEADBEEF;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic        valid;
        logic        chk_id;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares the DUT state after each edge against the queued expectation.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d never sampled", sb[0].name, sb[0].tag);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].tag == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".pc"}, fif.pc, e.pc);
            check({e.name, ".id_valid"}, 32'(fif.id_valid), 32'(e.valid));
            if (e.chk_id) begin
                check({e.name, ".id_pc"}, fif.id_pc, e.id_pc);
                check({e.name, ".id_instr"}, fif.id_instr, e.id_instr);
            end
        end
    end

    // Drive one edge's inputs and queue the state expected right after that edge.
    task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic e_v, input logic chk,
                        input logic [31:0] e_idpc, input logic [31:0] e_instr, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n             = rst;
        fif.stall         = st;
        fif.branch_taken  = br;
        fif.branch_target = tgt;
        e.tag      = cyc + 1;
        e.pc       = e_pc;
        e.valid    = e_v;
        e.chk_id   = chk;
        e.id_pc    = e_idpc;
        e.id_instr = e_instr;
        e.name     = nm;
        sb.push_back(e);
    endtask

    initial begin
        fif.stall         = 1'b0;
        fif.branch_taken  = 1'b0;
        fif.branch_target = '0;

        //   rst  st  br  tgt    pc     v  chk id_pc  id_instr
        step(0, 0, 0, 0,      0,     0, 0, 0,     0,            "reset0");
        step(0, 0, 0, 0,      0,     0, 0, 0,     0,            "reset1");
        step(1, 0, 0, 0,      4,     1, 1, 0,     32'hABCDEF12, "first");
        step(1, 0, 0, 0,      8,     1, 1, 4,     32'hBCDEF123, "seq4");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0,  8,     1, 1, 4,     32'hBCDEF123, "stall");
        step(1, 0, 0, 0,      12,    1, 1, 8,     32'hCDEF1234, "release");
        step(1, 0, 1, 52,     52,    0, 0, 0,     0,            "br52");
        step(1, 0, 0, 0,      56,    1, 1, 52,    32'h89ABCDEF, "tgt52");
        step(1, 0, 0, 0,      60,    1, 1, 56,    32'h9ABCDEF1, "seq56");
        step(1, 0, 0, 0,      0,     1, 1, 60,    32'hF000003C, "wrap_pc");
        step(1, 0, 0, 0,      4,     1, 1, 0,     32'hABCDEF12, "wrap_id");
        step(1, 0, 1, 31,     28,    0, 0, 0,     0,            "br31");
        step(1, 0, 0, 0,      32,    1, 1, 28,    32'h23456789, "tgt28");
        step(1, 1, 0, 0,      32,    1, 1, 28,    32'h23456789, "stall28");
        step(1, 1, 1, 8,      8,     0, 0, 0,     0,            "stall_br");
        step(1, 0, 0, 0,      12,    1, 1, 8,     32'hCDEF1234, "after_sb");
        step(1, 1, 0, 0,      12,    1, 1, 8,     32'hCDEF1234, "stall8a");
        step(1, 1, 0, 0,      12,    1, 1, 8,     32'hCDEF1234, "stall8b");
        step(0, 1, 0, 0,      0,     0, 0, 0,     0,            "rst_stall");
        step(1, 0, 0, 0,      4,     1, 1, 0,     32'hABCDEF12, "post_rst");
        step(1, 0, 1, 200,    200,   0, 0, 0,     0,            "br200");
        step(1, 1, 0, 0,      200,   0, 0, 0,     0,            "bubble_st0");
        step(1, 1, 0, 0,      200,   0, 0, 0,     0,            "bubble_st1");
        step(1, 0, 0, 0,      0,     1, 1, 200,   32'hDEADBEEF, "oob_wrap");
        step(1, 0, 0, 0,      4,     1, 1, 0,     32'hABCDEF12, "oob_next");

        @(negedge clk);
        fif.stall = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
